// File: rtl/dr_sync_sink.sv
// Dual-rail 4-phase sink: synchronizes asynchronous dual-rail tokens into the clock domain,
// acknowledges them with a 4-phase handshake and queues the captured words in a small FIFO.
module dr_sync_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] data_in,
  output logic               ack_ant,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  logic [2*WIDTH-1:0] r_sync1;
  logic [2*WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0]   w_true;
  logic [WIDTH-1:0]   w_false;
  logic               w_complete;
  logic               w_null;
  logic               w_illegal;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_ack;
  logic               w_write;
  logic               r_err;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_pop;
  logic               w_full;
  logic               w_wr_allowed;

  // Two-flop synchronizer on every rail; nothing below looks at raw data_in.
  // NOTE: sequential state always uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_true  = '0;
    w_false = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_true[i]  = r_sync2[2*i+1];
      w_false[i] = r_sync2[2*i];
    end
  end

  assign w_complete = &(w_true ^ w_false);
  assign w_null     = ~|r_sync2;
  assign w_illegal  = |(w_true & w_false);

  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready;
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_wr_allowed = !w_full || w_pop;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_complete && w_wr_allowed) begin
          w_write      = 1'b1;
          w_state_next = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (w_null) begin
          w_state_next = WAIT_DATA;
        end
      end
      default: w_state_next = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_DATA;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= (w_state_next == WAIT_NULL);
      r_err   <= r_err | w_illegal;
    end
  end

  // NOTE: storage is reset so out_data never shows X, even with an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= w_true;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ack_ant  = r_ack;
  assign out_data = r_mem[r_rd_ptr];
  assign err      = r_err;

endmodule

// File: tb/tb_dr_sync_sink.sv
// Self-checking bench for dr_sync_sink: a 4-phase dual-rail producer feeds tokens, a queue
// holds the words the sink must deliver, and a monitor compares every pop against it.
module tb_dr_sync_sink;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic [2*WIDTH-1:0] data_in;
  logic               ack_ant;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               err;

  logic [WIDTH-1:0]   exp_q[$];
  int                 n_checks;
  int                 n_errors;
  bit                 rand_ready;

  dr_sync_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .ack_ant   (ack_ant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ack_ant to reach val; n returns the number of rising edges taken.
  task automatic wait_ack(input logic val, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      n++;
      if (ack_ant == val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: ack_ant stuck at %0b, expected %0b at %0t", ack_ant, val, $time);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input bit chk_lat);
    int n;
    bit ok;
    data_in = enc(w);
    exp_q.push_back(w);
    wait_ack(1'b1, n, ok);
    if (chk_lat) check("ack_rise_latency", n, 3);
    data_in = '0;
    wait_ack(1'b0, n, ok);
    if (chk_lat) check("ack_fall_latency", n, 3);
  endtask

  // Monitor: every accepted output word must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got 0x%0h with nothing expected at %0t", out_data, $time);
        end else begin
          check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    logic [WIDTH-1:0] w;

    n_checks   = 0;
    n_errors   = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    data_in    = enc('0);
    #1;
    check("reset_ack", ack_ant, 0);
    check("reset_valid", out_valid, 0);
    check("reset_err", err, 0);
    check("reset_out_data", out_data, 0);

    // Upstream reset token (all data0) present as reset releases.
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back('0);
    wait_ack(1'b1, n, ok);
    check("first_token_ack_latency", n, 3);
    check("first_token_valid", out_valid, 1);
    check("first_token_data", out_data, 0);
    data_in = '0;
    wait_ack(1'b0, n, ok);
    check("first_token_null_latency", n, 3);
    out_ready = 1'b1;
    tick();
    check("first_token_drained", out_valid, 0);

    // Streaming with the consumer always ready.
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b1);
    tick();
    check("stream_drained", out_valid, 0);

    // Backpressure: four words fill the FIFO, the fifth is held until one pop.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
    check("full_valid", out_valid, 1);
    data_in = enc(8'h77);
    exp_q.push_back(8'h77);
    repeat (10) tick();
    check("held_token_ack", ack_ant, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("held_token_captured_on_pop", ack_ant, 1);
    data_in = '0;
    wait_ack(1'b0, n, ok);
    out_ready = 1'b1;
    repeat (3) tick();
    check("count_stayed_four", out_valid, 1);
    tick();
    check("fifo_empty_after_four", out_valid, 0);

    // Skewed rail arrival, bit 7 last; removal skewed the same way.
    w = 8'h5A;
    data_in = '0;
    data_in[1:0] = {w[0], ~w[0]};
    data_in[3:2] = {w[1], ~w[1]};
    exp_q.push_back(w);
    for (int i = 2; i < 7; i++) begin
      tick();
      data_in[2*i+1] = w[i];
      data_in[2*i]   = ~w[i];
    end
    repeat (4) tick();
    check("skew_no_early_ack", ack_ant, 0);
    data_in[15] = w[7];
    data_in[14] = ~w[7];
    wait_ack(1'b1, n, ok);
    check("skew_ack_latency", n, 3);
    for (int i = 0; i < 7; i++) begin
      data_in[2*i+1] = 1'b0;
      data_in[2*i]   = 1'b0;
      tick();
    end
    tick();
    check("skew_partial_null_holds", ack_ant, 1);
    data_in = '0;
    wait_ack(1'b0, n, ok);
    check("skew_null_latency", n, 3);
    tick();
    check("skew_one_word_only", out_valid, 0);

    // Illegal word: bit 2 with both rails high.
    data_in = enc(8'h0F);
    data_in[5] = 1'b1;
    data_in[4] = 1'b1;
    tick();
    tick();
    check("illegal_err_not_yet", err, 0);
    tick();
    check("illegal_err_set", err, 1);
    repeat (5) tick();
    check("illegal_no_ack", ack_ant, 0);
    check("illegal_no_write", out_valid, 0);
    data_in = '0;
    repeat (4) tick();
    send(8'hC3, 1'b1);
    check("err_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_reset", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in WAIT_NULL with two words queued.
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    data_in = enc(8'h22);
    exp_q.push_back(8'h22);
    wait_ack(1'b1, n, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", ack_ant, 0);
    check("async_reset_valid", out_valid, 0);
    exp_q.delete();
    data_in = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_empty", out_valid, 0);

    // Randomized tokens with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      send(8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 32 && out_valid; k++) tick();
    check("final_valid", out_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
